mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of the internal RAM (2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter IO_BASE, default 16'hFF00, meaning the base address of the memory-mapped IO window (IO_BASE..IO_BASE+3).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en_a  input  1  control-FSM port-A request enable.
REQ-006 SHALL have port we_a  input  1  port-A write enable, qualified by en_a.
REQ-007 SHALL have port addr_a  input  16  port-A word address (PC or load/store address).
REQ-008 SHALL have port din_a  input  16  port-A write data.
REQ-009 SHALL have port dout_a  output  16  port-A read data (instruction or load data).
REQ-010 SHALL have port b_req  input  1  port-B read request from a secondary reader (e.g. display).
REQ-011 SHALL have port b_addr  input  16  port-B word address.
REQ-012 SHALL have port b_ready  output  1  port-B request accepted this cycle.
REQ-013 SHALL have port b_rvalid  output  1  one-cycle pulse: b_rdata valid.
REQ-014 SHALL have port b_rdata  output  16  port-B read data.
REQ-015 SHALL have port switches  input  16  asynchronous board switches.
REQ-016 SHALL have port leds  output  16  LED output register.

Function
REQ-017 SHALL decode every address into RAM (addr < 2^ADDR_W), IO (IO_BASE..IO_BASE+3) or unmapped (all others).
REQ-018 SHALL, on en_a=1, we_a=0, present read data on dout_a exactly one cycle later (the FSM's fetch->decode and load->dout timing).
REQ-019 SHALL hold dout_a unchanged in every cycle without a port-A read, so the fetched instruction stays stable through decode/execute/branch.
REQ-020 SHALL, on en_a=1, we_a=1, write din_a into the addressed RAM word or writable IO register at that edge, leaving dout_a unchanged.
REQ-021 SHALL ignore writes to unmapped addresses, read-only IO registers and reserved IO register IO_BASE+3; unmapped and reserved reads SHALL return 16'h0000.
REQ-022 SHALL implement IO_BASE+0 LED register (read/write, drives leds), IO_BASE+1 switches (read-only, two-flop synchronised), IO_BASE+2 free-running cycle counter (read-only, +1 per cycle, wraps 16'hFFFF->16'h0000).
REQ-023 SHALL give port A absolute priority: b_ready = b_req AND NOT en_a, combinationally.
REQ-024 SHALL, when b_req=1 and b_ready=1, read b_addr and assert b_rvalid for exactly the next cycle with b_rdata valid; b_rdata SHALL hold its value afterwards.
REQ-025 SHALL, when b_req=1 and en_a=1, not accept port B (b_ready=0, no b_rvalid next cycle); the requester SHALL hold b_req/b_addr until b_ready.
REQ-026 SHALL return, for a read one cycle after a write to the same address, the newly written value.
REQ-027 SHALL apply the same address decode and read-data rules to port B, which SHALL never write.
REQ-028 SHALL implement a two-state port-B tracker: IDLE (b_rvalid=0) -> RESP on accepted request; RESP -> RESP on another accepted request, else IDLE.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set dout_a=0, b_rdata=0, b_rvalid=0, leds=0, cycle counter=0, switch synchronisers=0, tracker=IDLE.
REQ-030 SHALL, while reset=1, ignore port-A writes and port-B requests (b_ready=0); RAM contents SHALL NOT be cleared.
REQ-031 SHALL, on reset asserted mid-transaction, drop any pending b_rvalid in the following cycle.

Structure
REQ-032 SHALL take IO offsets (LED=0, SW=1, CNT=2) and IO_BASE default from the shared CPU package also holding opcode constants.
REQ-033 SHALL instantiate one sub-module, mem_ram_1rw, a single-port inferred block RAM (read-first, registered output); decode, IO and arbitration stay in mem_responder.

Verification
REQ-034 SHALL cover fetch: preload RAM[5]=16'h5312; en_a=1, addr_a=5 -> dout_a=16'h5312 next cycle, held for 3 idle cycles.
REQ-035 SHALL cover store/load: write 16'hBEEF to addr 16'h0020, then read 16'h0020 the next cycle -> dout_a=16'hBEEF one cycle later.
REQ-036 SHALL cover IO: write 16'h00A5 to 16'hFF00 -> leds=16'h00A5; switches=16'h1234 -> reading 16'hFF01 after 2 cycles returns 16'h1234; writing 16'hFF01 has no effect.
REQ-037 SHALL cover arbitration: b_req=1, b_addr=7 while en_a=1 for 2 cycles -> b_ready=0 both cycles; en_a=0 -> b_ready=1, b_rvalid=1 next cycle with RAM[7].
REQ-038 SHALL cover unmapped/wrap: read 16'h8000 -> 16'h0000; counter read after 65536 cycles from reset -> wrapped value.
REQ-039 SHALL cover reset mid-operation: reset=1 the cycle after a port-B accept -> b_rvalid=0, leds=0, dout_a=0; RAM contents preserved.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared CPU package: opcode constants, IO map and address decode helper used by the memory
// responder.
package mem_responder_pkg;

    // Opcode field values (instruction bits [15:12])
    localparam logic [3:0] OpAdd   = 4'h0;
    localparam logic [3:0] OpSub   = 4'h1;
    localparam logic [3:0] OpLoad  = 4'h2;
    localparam logic [3:0] OpStore = 4'h3;
    localparam logic [3:0] OpBr    = 4'h4;
    localparam logic [3:0] OpLdi   = 4'h5;
    localparam logic [3:0] OpHalt  = 4'hF;

    localparam logic [15:0] IoBaseDefault = 16'hFF00;
    localparam logic [1:0]  IoOffLed      = 2'd0;
    localparam logic [1:0]  IoOffSw       = 2'd1;
    localparam logic [1:0]  IoOffCnt      = 2'd2;

    typedef enum logic [1:0] {
        RegRam,
        RegIo,
        RegNone
    } region_e;

    typedef enum logic {
        TrkIdle,
        TrkResp
    } trk_state_e;

    // RAM wins over the IO window if a large ADDR_W makes them overlap.
    function automatic region_e decode_addr(input logic [15:0] addr,
                                            input logic [15:0] io_base,
                                            input int unsigned addr_w);
        logic [15:0] io_off;
        io_off = addr - io_base;
        if ({16'd0, addr} < (32'd1 << addr_w)) return RegRam;
        if (io_off < 16'd4) return RegIo;
        return RegNone;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU control FSM / secondary reader / board IO and the memory
// responder.
interface mem_responder_if;
    logic        en_a;
    logic        we_a;
    logic [15:0] addr_a;
    logic [15:0] din_a;
    logic [15:0] dout_a;
    logic        b_req;
    logic [15:0] b_addr;
    logic        b_ready;
    logic        b_rvalid;
    logic [15:0] b_rdata;
    logic [15:0] switches;
    logic [15:0] leds;

    modport master (
        output en_a, we_a, addr_a, din_a, b_req, b_addr, switches,
        input  dout_a, b_ready, b_rvalid, b_rdata, leds
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a, b_req, b_addr, switches,
        output dout_a, b_ready, b_rvalid, b_rdata, leds
    );
endinterface

// File: rtl/mem_ram_1rw.sv
// Single-port inferred block RAM, read-first with a registered read port. Contents are
// never reset.
module mem_ram_1rw #(
    parameter int unsigned AddrW = 10,
    parameter int unsigned DataW = 16
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [DataW-1:0] wdata_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [2**AddrW];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: RAM + memory-mapped IO behind one port, port A (CPU) with absolute priority
// over the port-B reader.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [15:0] IO_BASE = IoBaseDefault
) (
    input logic             clk,
    input logic             reset,
    mem_responder_if.slave  bus
);

    region_e     a_region, b_region, rd_region, rd_region_q;
    logic        a_rd, a_wr, b_acc, rd_active;
    logic [15:0] rd_addr;
    logic [1:0]  rd_off, wr_off;
    logic [15:0] rd_io_d, rd_io_q, rsp_data;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_rdata;

    logic        a_rd_q;
    logic [15:0] a_hold_q, b_hold_q, dout_a, b_rdata;
    logic [15:0] leds_q, cnt_q, sw_meta_q, sw_sync_q;
    trk_state_e  trk_q;

    assign a_region = decode_addr(bus.addr_a, IO_BASE, ADDR_W);
    assign b_region = decode_addr(bus.b_addr, IO_BASE, ADDR_W);

    assign a_rd  = bus.en_a & ~bus.we_a & ~reset;
    assign a_wr  = bus.en_a & bus.we_a & ~reset;
    assign b_acc = bus.b_req & ~bus.en_a & ~reset;
    assign bus.b_ready = b_acc;

    // Only one reader owns the shared read path in any cycle.
    assign rd_active = a_rd | b_acc;
    assign rd_addr   = bus.en_a ? bus.addr_a : bus.b_addr;
    assign rd_region = bus.en_a ? a_region : b_region;
    assign rd_off    = 2'(rd_addr - IO_BASE);
    assign wr_off    = 2'(bus.addr_a - IO_BASE);

    assign ram_en   = (bus.en_a & ~reset & (a_region == RegRam)) | (b_acc & (b_region == RegRam));
    assign ram_we   = a_wr & (a_region == RegRam);
    assign ram_addr = bus.en_a ? bus.addr_a[ADDR_W-1:0] : bus.b_addr[ADDR_W-1:0];

    mem_ram_1rw #(
        .AddrW (ADDR_W),
        .DataW (16)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.din_a),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        rd_io_d = '0;
        if (rd_region == RegIo) begin
            case (rd_off)
                IoOffLed: rd_io_d = leds_q;
                IoOffSw:  rd_io_d = sw_sync_q;
                IoOffCnt: rd_io_d = cnt_q;
                default:  rd_io_d = '0;
            endcase
        end
    end

    assign rsp_data = (rd_region_q == RegRam) ? ram_rdata : rd_io_q;

    // Outputs follow the fresh response for one cycle, then the hold registers keep them stable.
    assign dout_a  = a_rd_q ? rsp_data : a_hold_q;
    assign b_rdata = (trk_q == TrkResp) ? rsp_data : b_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rd_q      <= 1'b0;
            a_hold_q    <= '0;
            b_hold_q    <= '0;
            leds_q      <= '0;
            cnt_q       <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            rd_region_q <= RegNone;
            rd_io_q     <= '0;
            trk_q       <= TrkIdle;
        end else begin
            cnt_q     <= cnt_q + 16'd1;
            sw_meta_q <= bus.switches;
            sw_sync_q <= sw_meta_q;
            if (a_wr && (a_region == RegIo) && (wr_off == IoOffLed)) begin
                leds_q <= bus.din_a;
            end
            a_rd_q   <= a_rd;
            a_hold_q <= dout_a;
            b_hold_q <= b_rdata;
            if (rd_active) begin
                rd_region_q <= rd_region;
                rd_io_q     <= rd_io_d;
            end
            case (trk_q)
                TrkIdle: if (b_acc) trk_q <= TrkResp;
                TrkResp: if (!b_acc) trk_q <= TrkIdle;
                default: trk_q <= TrkIdle;
            endcase
        end
    end

    assign bus.dout_a   = dout_a;
    assign bus.b_rdata  = b_rdata;
    assign bus.b_rvalid = (trk_q == TrkResp);
    assign bus.leds     = leds_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed stimulus pushes expected read data, a monitor
// pops and compares whenever a response is due.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if bus_if ();

    mem_responder #(
        .ADDR_W  (10),
        .IO_BASE (16'hFF00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] a_exp_q[$];
    logic [15:0] b_exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cyc counts non-reset edges since the last reset edge, i.e. the cycle counter value.
    task automatic tick();
        @(posedge clk);
        if (reset) cyc = 0;
        else cyc++;
        #1;
    endtask

    task automatic a_write(input logic [15:0] addr, input logic [15:0] data);
        bus_if.en_a = 1'b1; bus_if.we_a = 1'b1; bus_if.addr_a = addr; bus_if.din_a = data;
        tick();
        bus_if.en_a = 1'b0; bus_if.we_a = 1'b0;
    endtask

    task automatic a_read(input logic [15:0] addr, input logic [15:0] exp);
        bus_if.en_a = 1'b1; bus_if.we_a = 1'b0; bus_if.addr_a = addr;
        a_exp_q.push_back(exp);
        tick();
        bus_if.en_a = 1'b0;
    endtask

    task automatic b_read(input logic [15:0] addr, input logic [15:0] exp);
        bus_if.b_req = 1'b1; bus_if.b_addr = addr;
        b_exp_q.push_back(exp);
        tick();
        bus_if.b_req = 1'b0;
    endtask

    // Monitor: decides from the stimulus alone whether a response is due after each edge.
    initial begin
        logic [15:0] a_model, b_model;
        logic        s_rst, s_ard, s_bacc;
        a_model = '0;
        b_model = '0;
        forever begin
            @(posedge clk);
            s_rst  = reset;
            s_ard  = bus_if.en_a && !bus_if.we_a && !reset;
            s_bacc = bus_if.b_req && !bus_if.en_a && !reset;
            chk("b_ready", {15'd0, bus_if.b_ready}, {15'd0, s_bacc});
            #2;
            if (s_rst) begin
                a_model = '0;
                b_model = '0;
            end
            if (s_ard) begin
                if (a_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_queue: got read response %h, want a queued expectation",
                             bus_if.dout_a);
                end else begin
                    a_model = a_exp_q.pop_front();
                end
            end
            chk("dout_a", bus_if.dout_a, a_model);
            if (s_bacc) begin
                if (b_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_queue: got read response %h, want a queued expectation",
                             bus_if.b_rdata);
                end else begin
                    b_model = b_exp_q.pop_front();
                end
            end
            chk("b_rvalid", {15'd0, bus_if.b_rvalid}, {15'd0, s_bacc});
            chk("b_rdata", bus_if.b_rdata, b_model);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus_if.en_a = 1'b0; bus_if.we_a = 1'b0; bus_if.addr_a = '0; bus_if.din_a = '0;
        bus_if.b_req = 1'b1; bus_if.b_addr = '0; bus_if.switches = '0;
        tick();
        tick();
        chk("rst_b_ready", {15'd0, bus_if.b_ready}, 16'd0);
        chk("rst_dout_a", bus_if.dout_a, 16'h0000);
        chk("rst_b_rdata", bus_if.b_rdata, 16'h0000);
        chk("rst_b_rvalid", {15'd0, bus_if.b_rvalid}, 16'd0);
        chk("rst_leds", bus_if.leds, 16'h0000);
        bus_if.b_req = 1'b0;
        reset = 1'b0;

        // Counter starts at 0 on the first edge out of reset.
        a_read(16'hFF02, 16'h0000);
        a_read(16'hFF02, 16'h0001);

        // Fetch and hold.
        a_write(16'h0005, 16'h5312);
        a_read(16'h0005, 16'h5312);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fetch_hold", bus_if.dout_a, 16'h5312);
        end

        // Store then load on the next cycle.
        a_write(16'h0020, 16'hBEEF);
        a_read(16'h0020, 16'hBEEF);

        // IO window.
        a_write(16'hFF00, 16'h00A5);
        chk("leds_write", bus_if.leds, 16'h00A5);
        bus_if.switches = 16'h1234;
        a_read(16'hFF01, 16'h0000);
        a_read(16'hFF01, 16'h0000);
        a_read(16'hFF01, 16'h1234);
        a_write(16'hFF01, 16'hFFFF);
        a_read(16'hFF01, 16'h1234);
        a_read(16'hFF00, 16'h00A5);
        a_write(16'hFF03, 16'h7777);
        a_read(16'hFF03, 16'h0000);
        chk("leds_after_ro", bus_if.leds, 16'h00A5);

        // Unmapped, including the first word past the RAM (must not alias RAM[0]).
        a_write(16'h0000, 16'h3333);
        a_write(16'h8000, 16'h1111);
        a_write(16'h0400, 16'h2222);
        a_read(16'h8000, 16'h0000);
        a_read(16'h0400, 16'h0000);
        a_read(16'h0000, 16'h3333);

        // Arbitration: port A blocks port B for two cycles.
        a_write(16'h0007, 16'h7777);
        bus_if.b_req = 1'b1; bus_if.b_addr = 16'h0007;
        bus_if.en_a = 1'b1; bus_if.we_a = 1'b0; bus_if.addr_a = 16'h0005;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("arb_blocked", {15'd0, bus_if.b_ready}, 16'd0);
            a_exp_q.push_back(16'h5312);
            tick();
            chk("arb_no_rvalid", {15'd0, bus_if.b_rvalid}, 16'd0);
        end
        bus_if.en_a = 1'b0;
        #1;
        chk("arb_granted", {15'd0, bus_if.b_ready}, 16'd1);
        b_exp_q.push_back(16'h7777);
        tick();
        bus_if.b_req = 1'b0;
        chk("arb_rvalid", {15'd0, bus_if.b_rvalid}, 16'd1);
        chk("arb_rdata", bus_if.b_rdata, 16'h7777);
        tick();

        // Back-to-back port-B reads across RAM, IO and unmapped space.
        bus_if.b_req = 1'b1;
        bus_if.b_addr = 16'h0005; b_exp_q.push_back(16'h5312); tick();
        bus_if.b_addr = 16'h0020; b_exp_q.push_back(16'hBEEF); tick();
        bus_if.b_addr = 16'hFF00; b_exp_q.push_back(16'h00A5); tick();
        bus_if.b_addr = 16'h8000; b_exp_q.push_back(16'h0000); tick();
        bus_if.b_req = 1'b0;
        tick();
        b_read(16'hFF01, 16'h1234);
        tick();

        // Counter wrap: 65541 cycles out of reset reads back as 5.
        while (cyc != 65541) tick();
        a_read(16'hFF02, 16'h0005);
        tick();

        // Reset right after a port-B accept; a write attempted under reset must be dropped.
        b_read(16'h0007, 16'h7777);
        chk("pre_rst_rvalid", {15'd0, bus_if.b_rvalid}, 16'd1);
        reset = 1'b1;
        bus_if.en_a = 1'b1; bus_if.we_a = 1'b1; bus_if.addr_a = 16'h0005; bus_if.din_a = 16'hDEAD;
        tick();
        chk("mid_rst_rvalid", {15'd0, bus_if.b_rvalid}, 16'd0);
        chk("mid_rst_leds", bus_if.leds, 16'h0000);
        chk("mid_rst_dout_a", bus_if.dout_a, 16'h0000);
        chk("mid_rst_b_rdata", bus_if.b_rdata, 16'h0000);
        reset = 1'b0;
        bus_if.en_a = 1'b0; bus_if.we_a = 1'b0;
        a_read(16'h0007, 16'h7777);
        a_read(16'h0005, 16'h5312);
        a_read(16'hFF00, 16'h0000);
        tick();
        tick();

        chk("a_queue_left", 16'(a_exp_q.size()), 16'd0);
        chk("b_queue_left", 16'(b_exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
